booth_radix4_encoder: RTL and testbench
=======================================

Name: booth_radix4_encoder

Overview:
- Registered radix-4 (modified Booth) partial-product generator for signed two's-complement operands.
- Recodes the multiplier into NUM_TERMS Booth digits in {-2,-1,0,+1,+2}.
- Forms each digit times the multiplicand, shifted into its weight position.
- Outputs all terms packed in one bus, feeding a downstream adder tree in the multiplier datapath.

Parameters:
- DATA_WIDTH, 6, operand width in bits; must be even and >= 4.
- NUM_TERMS, DATA_WIDTH/2 (3 at default), number of Booth digits / partial products; localparam.
- TERM_WIDTH, 2*DATA_WIDTH-1 (11 at default), width of each packed term; localparam.
- RESULT_WIDTH, TERM_WIDTH*NUM_TERMS (33 at default), width of the result bus; localparam.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- multiplicand  input  DATA_WIDTH  signed operand M.
- multiplier  input  DATA_WIDTH  signed operand B (the recoded operand).
- out_valid  output  1  result holds terms of a captured operand pair.
- result  output  RESULT_WIDTH  packed partial products; term i occupies bits [i*TERM_WIDTH +: TERM_WIDTH].

Behaviour:
- Reset (asynchronous, active-high): result = 0 and out_valid = 0 immediately; held while rst = 1.
- Digit recoding:
  - Use b[-1] = 0.
  - Digit i is taken from the triplet (b[2i+1], b[2i], b[2i-1]).
  - Mapping: 000→0, 001→+1, 010→+1, 011→+2, 100→-2, 101→-1, 110→-1, 111→0.
- Term generation:
  - Term i = (digit_i * M) << 2i, computed sign-extended at 2*DATA_WIDTH bits.
  - The low TERM_WIDTH bits are stored (truncation).
  - ±2M is M << 1 and negation is two's complement; no separate correction/sign bits.
- Sum property: the sum of the stored terms mod 2^TERM_WIDTH equals M*B mod 2^TERM_WIDTH.
- Latency and handshake:
  - Each rising clk with in_valid = 1 registers new terms into result and sets out_valid = 1 one cycle later.
  - With in_valid = 0, result holds its previous value and out_valid = 0 next cycle.
  - No back-pressure; a new pair is accepted every cycle.
- Back-to-back inputs are independent; no state beyond the output registers.
- Reset asserted mid-stream discards the in-flight pair; the first valid input after reset release yields out_valid exactly one cycle later.
- Fully combinational recode/term logic between input and register; no multi-cycle paths.

Optional Feature:
- Macro: BOOTH_PRODUCT_EN.
- When defined:
  - Adds output product, width 2*DATA_WIDTH, signed.
  - Registered in the same cycle as result.
  - Equals the exact M*B, computed by summing the full 2*DATA_WIDTH-bit sign-extended terms, not the truncated ones.
  - Reset value 0.
- When undefined: port and adder are absent, and the result/out_valid behaviour is identical.

Decomposition:
- Package booth_pkg:
  - booth_digit_t: 3-bit encoding with neg, one and two flags.
  - DATA_WIDTH default constant.
  - Function recoding a 3-bit triplet to booth_digit_t.
- One natural sub-module, booth_pp_gen: one digit plus M produces one shifted term; instantiated NUM_TERMS times via generate.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → result = 0 and out_valid = 0 without waiting for a clk edge.
- Nominal pair: M = 6'b110101 (-11), B = 6'b011011 (27), in_valid = 1
  - Digits are (-1, -1, +2).
  - Next cycle: result[10:0] = 0x00B, [21:11] = 0x02C, [32:22] = 0x6A0; out_valid = 1.
  - With BOOTH_PRODUCT_EN: product = -297 (12'hED7).
- Zero and most-negative multiplier:
  - M = 0, any B → result = 0.
  - M = 5, B = 6'b100000 → terms 0x000, 0x000, 0x760 (-2*5<<4).
- Extreme operands: M = B = -32 → terms 0, 0, 0x400 (truncated); with BOOTH_PRODUCT_EN, product = 1024 (12'h400).
- Handshake:
  - Drive valid pairs on 3 consecutive cycles, then in_valid = 0 → out_valid high for exactly 3 cycles, each result matching its pair.
  - result holds the last value afterwards.
- Random: 1000 random signed pairs → sum of terms mod 2^11 equals M*B mod 2^11 (and product exact when enabled).

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth partial-product generator.
// Provides the default operand width, the digit encoding and the triplet recoder.
package booth_pkg;

    localparam int BOOTH_DATA_WIDTH = 6;

    // Digit value = (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0)
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_t booth_recode(input logic [2:0] t);
        booth_digit_t d;
        d = '0;
        unique case (t)
            3'b001, 3'b010: d.one = 1'b1;
            3'b011:         d.two = 1'b1;
            3'b100: begin
                d.neg = 1'b1;
                d.two = 1'b1;
            end
            3'b101, 3'b110: begin
                d.neg = 1'b1;
                d.one = 1'b1;
            end
            default:        d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth partial product: digit * M, shifted left by SHIFT, in OUT_WIDTH bits.
// Ports: digit (recoded Booth digit), m (signed multiplicand), term (shifted product).
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH = BOOTH_DATA_WIDTH,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH,
    parameter int SHIFT      = 0
) (
    input  booth_digit_t            digit,
    input  logic [DATA_WIDTH-1:0]   m,
    output logic [OUT_WIDTH-1:0]    term
);

    logic [OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] mag;
    logic [OUT_WIDTH-1:0] val;

    // Working directly in OUT_WIDTH bits is safe: truncation commutes with
    // sign extension, doubling, negation and left shifts.
    always_comb begin
        ext = {{(OUT_WIDTH-DATA_WIDTH){m[DATA_WIDTH-1]}}, m};
        if (digit.two)
            mag = ext << 1;
        else if (digit.one)
            mag = ext;
        else
            mag = '0;
        val  = digit.neg ? ('0 - mag) : mag;
        term = val << SHIFT;
    end

endmodule

// File: rtl/booth_radix4_encoder.sv
// Registered radix-4 Booth partial-product generator for signed operands.
// Ports: clk, rst (async high), in_valid, multiplicand, multiplier -> out_valid,
// result (NUM_TERMS packed terms); product (exact M*B) when BOOTH_PRODUCT_EN is defined.
module booth_radix4_encoder
    import booth_pkg::*;
#(
    parameter  int DATA_WIDTH   = BOOTH_DATA_WIDTH,
    localparam int NUM_TERMS    = DATA_WIDTH/2,
    localparam int TERM_WIDTH   = 2*DATA_WIDTH-1,
    localparam int RESULT_WIDTH = TERM_WIDTH*NUM_TERMS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         multiplicand,
    input  logic [DATA_WIDTH-1:0]         multiplier,
    output logic                          out_valid,
    output logic [RESULT_WIDTH-1:0]       result
`ifdef BOOTH_PRODUCT_EN
    ,
    output logic signed [2*DATA_WIDTH-1:0] product
`endif
);

`ifdef BOOTH_PRODUCT_EN
    // The exact product needs full-width terms.
    localparam int GEN_WIDTH = 2*DATA_WIDTH;
`else
    localparam int GEN_WIDTH = TERM_WIDTH;
`endif

    // Appending b[-1] = 0 lets every triplet be a plain 3-bit slice.
    logic [DATA_WIDTH:0]     bext;
    logic [GEN_WIDTH-1:0]    terms [NUM_TERMS];
    logic [RESULT_WIDTH-1:0] packed_terms;

    assign bext = {multiplier, 1'b0};

    for (genvar i = 0; i < NUM_TERMS; i++) begin : g_pp
        booth_digit_t d;
        assign d = booth_recode(bext[2*i +: 3]);

        booth_pp_gen #(
            .DATA_WIDTH (DATA_WIDTH),
            .OUT_WIDTH  (GEN_WIDTH),
            .SHIFT      (2*i)
        ) u_pp (
            .digit (d),
            .m     (multiplicand),
            .term  (terms[i])
        );

        assign packed_terms[i*TERM_WIDTH +: TERM_WIDTH] =
            terms[i][TERM_WIDTH-1:0];
    end

`ifdef BOOTH_PRODUCT_EN
    logic [2*DATA_WIDTH-1:0] prod_sum;

    always_comb begin
        prod_sum = '0;
        for (int i = 0; i < NUM_TERMS; i++)
            prod_sum = prod_sum + terms[i];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
`ifdef BOOTH_PRODUCT_EN
            product   <= '0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result  <= packed_terms;
`ifdef BOOTH_PRODUCT_EN
                product <= prod_sum;
`endif
            end
        end
    end

endmodule

// File: tb/tb_booth_radix4_encoder.sv
// Self-checking bench for booth_radix4_encoder (default width 6).
// Scoreboard queue of expected terms/product; immediate assertions at each check.
module tb_booth_radix4_encoder;

    localparam int DW = 6;
    localparam int TW = 2*DW-1;
    localparam int NT = DW/2;
    localparam int RW = TW*NT;

    typedef struct {
        logic [RW-1:0]   res;
        logic [2*DW-1:0] prod;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic            out_valid;
    logic [RW-1:0]   result;
`ifdef BOOTH_PRODUCT_EN
    logic signed [2*DW-1:0] product;
`endif

    exp_t        q[$];
    logic [RW-1:0] last_exp;
    int          checks = 0;
    int          fails  = 0;

    booth_radix4_encoder #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .result       (result)
`ifdef BOOTH_PRODUCT_EN
        ,
        .product      (product)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent model: digit = -2*b[2i+1] + b[2i] + b[2i-1]
    function automatic exp_t model(input logic signed [DW-1:0] m,
                                   input logic signed [DW-1:0] b);
        exp_t        e;
        logic [DW:0] bx;
        int          d;
        int          t;
        logic [31:0] tv;
        bx    = {b, 1'b0};
        e.res = '0;
        for (int i = 0; i < NT; i++) begin
            d  = -2*int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            t  = d * int'(m) * (1 << (2*i));
            tv = t;
            e.res[i*TW +: TW] = tv[TW-1:0];
        end
        tv     = int'(m) * int'(b);
        e.prod = tv[2*DW-1:0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] m,
                        input logic [DW-1:0] b);
        exp_t        e;
        logic [31:0] s;
        @(negedge clk);
        in_valid     = v;
        multiplicand = m;
        multiplier   = b;
        if (v) q.push_back(model(m, b));
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(v));
        if (v) begin
            if (q.size() == 0) begin
                chk("queue_empty", 64'(1), 64'(0));
            end else begin
                e = q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                s = '0;
                for (int i = 0; i < NT; i++)
                    s = s + 32'(result[i*TW +: TW]);
                chk("modsum", 64'(s[TW-1:0]), 64'(e.prod[TW-1:0]));
`ifdef BOOTH_PRODUCT_EN
                chk("product", 64'(product), 64'(e.prod));
`endif
                last_exp = e.res;
            end
        end else begin
            chk("hold", 64'(result), 64'(last_exp));
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        last_exp     = '0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Nominal: digits (-1,-1,+2)
        step(1'b1, 6'b110101, 6'b011011);
        chk("nom_t0", 64'(result[10:0]), 64'(11'h00B));
        chk("nom_t1", 64'(result[21:11]), 64'(11'h02C));
        chk("nom_t2", 64'(result[32:22]), 64'(11'h6A0));
`ifdef BOOTH_PRODUCT_EN
        chk("nom_prod", 64'(product), 64'(12'hED7));
`endif

        // Asynchronous reset away from the clock edge
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 64'(out_valid), 64'(0));
        chk("async_result", 64'(result), 64'(0));
        @(negedge clk);
        rst      = 1'b0;
        last_exp = '0;

        step(1'b1, 6'd0, 6'b101101);
        chk("m0_result", 64'(result), 64'(0));
        step(1'b1, 6'd5, 6'b100000);
        chk("mneg_t2", 64'(result[32:22]), 64'(11'h760));
        chk("mneg_lo", 64'(result[21:0]), 64'(0));
        step(1'b1, 6'b100000, 6'b100000);
        chk("ext_t2", 64'(result[32:22]), 64'(11'h400));
        chk("ext_lo", 64'(result[21:0]), 64'(0));
`ifdef BOOTH_PRODUCT_EN
        chk("ext_prod", 64'(product), 64'(12'h400));
`endif

        // Handshake: three back-to-back pairs then idle
        step(1'b1, 6'd7, 6'd9);
        step(1'b1, 6'b111111, 6'b011111);
        step(1'b1, 6'd31, 6'b100001);
        step(1'b0, 6'd3, 6'd3);
        step(1'b0, 6'd12, 6'd21);

        // Reset mid-stream discards the in-flight pair
        @(negedge clk);
        in_valid     = 1'b1;
        multiplicand = 6'd11;
        multiplier   = 6'd13;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_valid", 64'(out_valid), 64'(0));
        chk("mid_result", 64'(result), 64'(0));
        @(posedge clk);
        #1;
        chk("mid_hold_valid", 64'(out_valid), 64'(0));
        chk("mid_hold_result", 64'(result), 64'(0));
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        last_exp = '0;
        step(1'b1, 6'b101010, 6'b010101);

        for (int n = 0; n < 1000; n++)
            step(($urandom_range(0, 3) != 0),
                 DW'($urandom), DW'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
